// File: rtl/seven_seg_to_binary_rx.sv
// Seven-segment receive decoder: debounces a segment pattern and returns its hex value on a val/rdy port.
// Optional SEVEN_SEG_RX_ERR_COUNT_EN adds a saturating count of transferred error codes on err_count.
module seven_seg_to_binary_rx #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] seg_in,
   output logic       out_val,
   input  logic       out_rdy,
   output logic [3:0] out_data,
   output logic       out_err
`ifdef SEVEN_SEG_RX_ERR_COUNT_EN
   ,
   output logic [7:0] err_count
`endif
);
   localparam logic [6:0] BLANK  = 7'b1111111;
   localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

   typedef enum logic [1:0] {IDLE, SETTLE, VALID} state_t;
   state_t state, state_nxt;

   logic [6:0] cand, last, held;
   logic [6:0] last_nxt, held_nxt;
   logic [7:0] count, count_nxt;
   logic       out_val_nxt, out_err_nxt;
   logic [3:0] out_data_nxt;
   logic [3:0] dec_data;
   logic       dec_err;
   logic       stable;
   logic       xfer;

   assign xfer = out_val && out_rdy;

   always_comb begin
      dec_data = '0;
      dec_err  = 1'b0;
      case (seg_in)
         7'b1000000: dec_data = 4'h0;
         7'b1111001: dec_data = 4'h1;
         7'b0100100: dec_data = 4'h2;
         7'b0110000: dec_data = 4'h3;
         7'b0011001: dec_data = 4'h4;
         7'b0010010: dec_data = 4'h5;
         7'b0000010: dec_data = 4'h6;
         7'b1111000: dec_data = 4'h7;
         7'b0000000: dec_data = 4'h8;
         7'b0010000: dec_data = 4'h9;
         7'b0001000: dec_data = 4'hA;
         7'b0000011: dec_data = 4'hB;
         7'b1000110: dec_data = 4'hC;
         7'b0100001: dec_data = 4'hD;
         7'b0000110: dec_data = 4'hE;
         7'b0001110: dec_data = 4'hF;
         default:    dec_err  = 1'b1;
      endcase
   end

   // Stability is judged on the count this edge will load, so a decode lands on edge STABLE_CYCLES.
   always_comb begin
      if (seg_in != cand)      count_nxt = 8'd1;
      else if (count == STABLE) count_nxt = count;
      else                     count_nxt = count + 8'd1;
      stable = (count_nxt == STABLE);
   end

   always_comb begin
      state_nxt    = state;
      last_nxt     = last;
      held_nxt     = held;
      out_val_nxt  = out_val;
      out_data_nxt = out_data;
      out_err_nxt  = out_err;
      case (state)
         IDLE: begin
            if (seg_in != last) state_nxt = SETTLE;
         end
         SETTLE: begin
            if (seg_in == last) begin
               state_nxt = IDLE;
            end else if (stable) begin
               if (seg_in == BLANK) begin
                  state_nxt = IDLE;
                  last_nxt  = BLANK;
               end else begin
                  state_nxt    = VALID;
                  held_nxt     = seg_in;
                  out_val_nxt  = 1'b1;
                  out_data_nxt = dec_data;
                  out_err_nxt  = dec_err;
               end
            end
         end
         VALID: begin
            // A different, possibly already-stable input re-enters SETTLE with its count intact.
            if (xfer) begin
               last_nxt    = held;
               out_val_nxt = 1'b0;
               state_nxt   = (seg_in != held) ? SETTLE : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cand     <= BLANK;
         count    <= '0;
         last     <= BLANK;
         held     <= BLANK;
         out_val  <= 1'b0;
         out_data <= '0;
         out_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         cand     <= seg_in;
         count    <= count_nxt;
         last     <= last_nxt;
         held     <= held_nxt;
         out_val  <= out_val_nxt;
         out_data <= out_data_nxt;
         out_err  <= out_err_nxt;
      end
   end

`ifdef SEVEN_SEG_RX_ERR_COUNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                  err_count <= '0;
      else if (xfer && out_err && err_count != '1) err_count <= err_count + 8'd1;
   end
`endif

endmodule

// File: tb/tb_seven_seg_to_binary_rx.sv
// Self-checking bench for seven_seg_to_binary_rx: directed scenarios plus randomized traffic vs a run-length model.
// Build with SEVEN_SEG_RX_ERR_COUNT_EN defined to also check err_count.
module tb_seven_seg_to_binary_rx;
   localparam int N = 4;
   localparam logic [6:0] BLANK = 7'b1111111;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] seg_in;
   logic       out_val;
   logic       out_rdy;
   logic [3:0] out_data;
   logic       out_err;
`ifdef SEVEN_SEG_RX_ERR_COUNT_EN
   logic [7:0] err_count;
`endif

   int tests = 0;
   int fails = 0;

   // Reference model: stability = last N samples since reset all equal.
   logic [6:0] hist[$];
   logic       m_pend;
   logic [6:0] m_pat;
   logic [6:0] m_last;
   int         m_errcnt;

   logic [6:0] tbl[16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   seven_seg_to_binary_rx #(.STABLE_CYCLES(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .seg_in   (seg_in),
      .out_val  (out_val),
      .out_rdy  (out_rdy),
      .out_data (out_data),
      .out_err  (out_err)
`ifdef SEVEN_SEG_RX_ERR_COUNT_EN
      ,
      .err_count(err_count)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
      $fatal(1, "timeout");
   end

   function automatic void ref_decode(input logic [6:0] p, output logic [3:0] d, output logic e);
      d = 4'h0;
      e = 1'b1;
      for (int i = 0; i < 16; i++)
         if (tbl[i] == p) begin
            d = 4'(i);
            e = 1'b0;
         end
   endfunction

   function automatic void model_clear();
      hist.delete();
      m_pend   = 1'b0;
      m_pat    = BLANK;
      m_last   = BLANK;
      m_errcnt = 0;
   endfunction

   // Drives one clock edge and advances the model; leaves time at posedge+1.
   task automatic step(input logic [6:0] s, input logic r);
      logic [3:0] d;
      logic       e;
      logic       run;
      seg_in  = s;
      out_rdy = r;
      @(posedge clk);
      hist.push_back(s);
      if (hist.size() > N) void'(hist.pop_front());
      if (m_pend && r) begin
         ref_decode(m_pat, d, e);
         if (e && m_errcnt < 255) m_errcnt++;
         m_last = m_pat;
         m_pend = 1'b0;
      end else if (!m_pend) begin
         run = (hist.size() == N);
         foreach (hist[i]) if (hist[i] != s) run = 1'b0;
         if (run && s != m_last) begin
            if (s == BLANK) m_last = BLANK;
            else begin
               m_pend = 1'b1;
               m_pat  = s;
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      seg_in = BLANK;
      out_rdy = 1'b0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (out_val !== 1'b0 || out_data !== 4'h0 || out_err !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs: actual val=%b data=%h err=%b required 0 0 0", out_val, out_data, out_err);
      end
`ifdef SEVEN_SEG_RX_ERR_COUNT_EN
      tests++;
      if (err_count !== 8'd0) begin
         fails++;
         $display("FAIL reset_err_count: actual %0d required 0", err_count);
      end
`endif
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_single_digit();
      for (int i = 0; i < 10; i++) begin
         step(7'b1000000, 1'b1);
         tests++;
         if (out_val !== (i == N - 1)) begin
            fails++;
            $display("FAIL digit0_val edge%0d: actual %b required %b", i + 1, out_val, (i == N - 1));
         end
         if (i == N - 1) begin
            tests++;
            if (out_data !== 4'h0 || out_err !== 1'b0) begin
               fails++;
               $display("FAIL digit0_data: actual data=%h err=%b required 0 0", out_data, out_err);
            end
         end
      end
   endtask

   task automatic test_mid_change();
      for (int i = 0; i < 3; i++) begin
         step(7'b0100100, 1'b1);
         tests++;
         if (out_val !== 1'b0) begin
            fails++;
            $display("FAIL partial2_val edge%0d: actual %b required 0", i + 1, out_val);
         end
      end
      for (int i = 0; i < N; i++) begin
         step(7'b0110000, 1'b1);
         tests++;
         if (out_val !== (i == N - 1)) begin
            fails++;
            $display("FAIL digit3_val edge%0d: actual %b required %b", i + 1, out_val, (i == N - 1));
         end
      end
      tests++;
      if (out_data !== 4'h3 || out_err !== 1'b0) begin
         fails++;
         $display("FAIL digit3_data: actual data=%h err=%b required 3 0", out_data, out_err);
      end
      step(7'b0110000, 1'b1);
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < N + 10; i++) begin
         step(7'b0001000, 1'b0);
         if (i >= N - 1) begin
            tests++;
            if (out_val !== 1'b1 || out_data !== 4'hA) begin
               fails++;
               $display("FAIL hold_A cyc%0d: actual val=%b data=%h required 1 a", i, out_val, out_data);
            end
         end
      end
      for (int i = 0; i < N + 2; i++) begin
         step(7'b0000011, 1'b0);
         tests++;
         if (out_val !== 1'b1 || out_data !== 4'hA) begin
            fails++;
            $display("FAIL hold_A_newin cyc%0d: actual val=%b data=%h required 1 a", i, out_val, out_data);
         end
      end
      step(7'b0000011, 1'b1);
      tests++;
      if (out_val !== 1'b0) begin
         fails++;
         $display("FAIL after_A_xfer_val: actual %b required 0", out_val);
      end
      step(7'b0000011, 1'b0);
      tests++;
      if (out_val !== 1'b1 || out_data !== 4'hB) begin
         fails++;
         $display("FAIL b_next_edge: actual val=%b data=%h required 1 b", out_val, out_data);
      end
      step(7'b0000011, 1'b1);
   endtask

   task automatic test_blank_redeliver();
      int seen = 0;
      for (int i = 0; i < N + 1; i++) begin
         step(7'b0000000, 1'b1);
         if (out_val === 1'b1) seen++;
      end
      for (int i = 0; i < N; i++) begin
         step(BLANK, 1'b1);
         if (out_val === 1'b1) seen++;
      end
      for (int i = 0; i < 25; i++) begin
         step(7'b0000000, 1'b1);
         if (out_val === 1'b1) begin
            seen++;
            tests++;
            if (out_data !== 4'h8) begin
               fails++;
               $display("FAIL redeliver_data: actual %h required 8", out_data);
            end
         end
      end
      tests++;
      if (seen != 2) begin
         fails++;
         $display("FAIL deliveries_of_8: actual %0d required 2", seen);
      end
   endtask

   task automatic test_invalid();
      for (int i = 0; i < N; i++) step(7'b0101010, 1'b0);
      tests++;
      if (out_val !== 1'b1 || out_err !== 1'b1 || out_data !== 4'h0) begin
         fails++;
         $display("FAIL invalid_out: actual val=%b err=%b data=%h required 1 1 0", out_val, out_err, out_data);
      end
      step(7'b0101010, 1'b1);
`ifdef SEVEN_SEG_RX_ERR_COUNT_EN
      tests++;
      if (err_count !== 8'd1) begin
         fails++;
         $display("FAIL err_count_one: actual %0d required 1", err_count);
      end
`endif
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < N; i++) step(7'b1111000, 1'b0);
      tests++;
      if (out_val !== 1'b1 || out_data !== 4'h7) begin
         fails++;
         $display("FAIL pre_reset_val: actual val=%b data=%h required 1 7", out_val, out_data);
      end
      #1;
      rst = 1'b0;
      model_clear();
      #1;
      tests++;
      if (out_val !== 1'b0 || out_data !== 4'h0 || out_err !== 1'b0) begin
         fails++;
         $display("FAIL async_drop: actual val=%b data=%h err=%b required 0 0 0", out_val, out_data, out_err);
      end
      seg_in = 7'b1111001;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         step(7'b1111001, 1'b0);
         tests++;
         if (out_val !== (i == N - 1)) begin
            fails++;
            $display("FAIL post_reset_val edge%0d: actual %b required %b", i + 1, out_val, (i == N - 1));
         end
      end
      tests++;
      if (out_data !== 4'h1 || out_err !== 1'b0) begin
         fails++;
         $display("FAIL post_reset_data: actual data=%h err=%b required 1 0", out_data, out_err);
      end
      step(7'b1111001, 1'b1);
   endtask

   task automatic test_random();
      logic [6:0] p;
      logic [3:0] d;
      logic       e;
      int         sel;
      for (int n = 0; n < 600; n++) begin
         sel = int'($urandom_range(0, 21));
         if (sel < 16)      p = tbl[sel];
         else if (sel < 19) p = BLANK;
         else               p = 7'($urandom);
         for (int k = 0; k < int'($urandom_range(1, 7)); k++) begin
            step(p, ($urandom_range(0, 9) < 6));
            tests++;
            if (out_val !== m_pend) begin
               fails++;
               $display("FAIL rand_val n%0d: actual %b required %b", n, out_val, m_pend);
            end
            if (m_pend) begin
               ref_decode(m_pat, d, e);
               tests++;
               if (out_data !== d || out_err !== e) begin
                  fails++;
                  $display("FAIL rand_data n%0d: actual data=%h err=%b required %h %b", n, out_data, out_err, d, e);
               end
            end
`ifdef SEVEN_SEG_RX_ERR_COUNT_EN
            tests++;
            if (int'(err_count) != m_errcnt) begin
               fails++;
               $display("FAIL rand_err_count n%0d: actual %0d required %0d", n, err_count, m_errcnt);
            end
`endif
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_digit();
      test_mid_change();
      test_backpressure();
      test_blank_redeliver();
      test_invalid();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
